// File: rtl/mmio_timer_led.sv
// mmio_timer_led: memory-mapped LED register plus a 32-bit prescaled timer with
// compare match, auto-reload and a level interrupt.
//
// The peripheral decodes one 256-byte window. Stores are registered; loads are
// combinational, so a single-cycle core's load completes in its own cycle.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous reset, active low
//   addr     - byte address; [31:8] select the window, [7:2] the register
//   wdata    - store data
//   be       - byte enables for stores, be[i] gates wdata[8i+7:8i]
//   we       - store strobe, sampled on the rising edge
//   re       - load strobe, qualifies rdata combinationally
//   hit      - address falls inside the window
//   rdata    - load data, zero unless re && hit
//   LED_out  - LED register contents
//   irq      - timer interrupt request (MATCH & IRQ_EN), level
//
// Register map (word offsets, addr[1:0] ignored):
//   0x00 LED, 0x04 CTRL {IRQ_EN, AUTO_RELOAD, EN}, 0x08 COUNT,
//   0x0C PRESCALE (16 bit), 0x10 COMPARE, 0x14 STATUS {MATCH} (write 1 to clear)

module mmio_timer_led #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned LED_W     = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    input  logic             we,
    input  logic             re,
    output logic             hit,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] LED_out,
    output logic             irq
);

    localparam logic [5:0] OffLed      = 6'h00;
    localparam logic [5:0] OffCtrl     = 6'h01;
    localparam logic [5:0] OffCount    = 6'h02;
    localparam logic [5:0] OffPrescale = 6'h03;
    localparam logic [5:0] OffCompare  = 6'h04;
    localparam logic [5:0] OffStatus   = 6'h05;

    logic [LED_W-1:0] led_q, led_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      count_q, count_d;
    logic [15:0]      prescale_q, prescale_d;
    logic [31:0]      compare_q, compare_d;
    logic             match_q, match_d;
    logic [15:0]      pre_cnt_q, pre_cnt_d;

    logic [5:0] word;
    logic       wr_en;
    logic       wr_led, wr_ctrl, wr_count, wr_prescale, wr_compare, wr_status;
    logic       tick;
    logic       cnt_at_cmp;
    logic       match_evt;
    logic       unused_addr;

    assign unused_addr = ^addr[1:0];

    // Byte-lane merge of a store into a 32-bit register.
    function automatic logic [31:0] merge32(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign hit  = (addr[31:8] == BASE_ADDR[31:8]);
    assign word = addr[7:2];

    always_comb begin
        wr_en       = we && hit;
        wr_led      = wr_en && (word == OffLed);
        wr_ctrl     = wr_en && (word == OffCtrl);
        wr_count    = wr_en && (word == OffCount);
        wr_prescale = wr_en && (word == OffPrescale);
        wr_compare  = wr_en && (word == OffCompare);
        wr_status   = wr_en && (word == OffStatus);
    end

    assign tick       = ctrl_q[0] && (pre_cnt_q == prescale_q);
    assign cnt_at_cmp = (count_q == compare_q);
    // A CPU store to COUNT on a tick edge suppresses that tick's match.
    assign match_evt  = tick && cnt_at_cmp && !wr_count;

    always_comb begin
        led_d      = led_q;
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        match_d    = match_q;
        pre_cnt_d  = pre_cnt_q;

        if (wr_led) begin
            for (int i = 0; i < LED_W; i++) begin
                if (be[i/8]) led_d[i] = wdata[i];
            end
        end

        if (wr_ctrl && be[0]) ctrl_d = wdata[2:0];

        if (wr_prescale) begin
            for (int i = 0; i < 16; i++) begin
                if (be[i/8]) prescale_d[i] = wdata[i];
            end
        end

        if (wr_compare) compare_d = merge32(compare_q, wdata, be);

        // Prescaler idles at zero while disabled; any PRESCALE store restarts it.
        if (!ctrl_q[0] || tick || wr_prescale) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 16'd1;
        end

        if (wr_count) begin
            count_d = merge32(count_q, wdata, be);
        end else if (tick) begin
            count_d = (cnt_at_cmp && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
        end

        // Clear first so a same-edge match wins.
        if (wr_status && be[0] && wdata[0]) match_d = 1'b0;
        if (match_evt) match_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q      <= '0;
            ctrl_q     <= '0;
            count_q    <= '0;
            prescale_q <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            pre_cnt_q  <= '0;
        end else begin
            led_q      <= led_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            pre_cnt_q  <= pre_cnt_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (re && hit) begin
            case (word)
                OffLed:      rdata[LED_W-1:0] = led_q;
                OffCtrl:     rdata[2:0]       = ctrl_q;
                OffCount:    rdata            = count_q;
                OffPrescale: rdata[15:0]      = prescale_q;
                OffCompare:  rdata            = compare_q;
                OffStatus:   rdata[0]         = match_q;
                default:     rdata            = '0;
            endcase
        end
    end

    assign LED_out = led_q;
    assign irq     = match_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_timer_led.sv
// Testbench for mmio_timer_led: register vector table, randomized traffic against
// a behavioural model, and hand-written timer corner-case sequences.

`timescale 1ns/100ps

module tb_mmio_timer_led;

    localparam logic [31:0] Base = 32'h1000_0000;
    localparam int          Lw   = 18;

    localparam logic [31:0] ALed  = Base + 32'h00;
    localparam logic [31:0] ACtrl = Base + 32'h04;
    localparam logic [31:0] ACnt  = Base + 32'h08;
    localparam logic [31:0] APre  = Base + 32'h0C;
    localparam logic [31:0] ACmp  = Base + 32'h10;
    localparam logic [31:0] AStat = Base + 32'h14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    be = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic          hit;
    logic [31:0]   rdata;
    logic [Lw-1:0] LED_out;
    logic          irq;

    mmio_timer_led #(
        .BASE_ADDR(Base),
        .LED_W    (Lw)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .be     (be),
        .we     (we),
        .re     (re),
        .hit    (hit),
        .rdata  (rdata),
        .LED_out(LED_out),
        .irq    (irq)
    );

    always #10 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: architectural register values.
    logic [31:0] m_led, m_count, m_cmp;
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre, m_pcnt;
    logic        m_match;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_led = 0; m_ctrl = 0; m_count = 0; m_pre = 0;
        m_cmp = 32'hFFFF_FFFF; m_match = 0; m_pcnt = 0;
    endtask

    // One rising edge with the inputs currently applied.
    task automatic model_step();
        bit          wr, tick, matched, clr;
        logic [7:0]  off;
        logic [31:0] t, old_count;
        wr        = we && (addr[31:8] == Base[31:8]);
        off       = {addr[7:2], 2'b00};
        old_count = m_count;
        tick      = m_ctrl[0] && (m_pcnt == m_pre);
        matched   = tick && (m_count == m_cmp) && !(wr && off == 8'h08);
        clr       = wr && off == 8'h14 && be[0] && wdata[0];
        if (!m_ctrl[0] || tick) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
        if (tick) m_count = (m_count == m_cmp && m_ctrl[1]) ? 0 : m_count + 1;
        if (wr) begin
            case (off)
                8'h00: begin
                    t = bmerge(m_led, wdata, be);
                    m_led = t & ((32'd1 << Lw) - 1);
                end
                8'h04: begin
                    t = bmerge({29'd0, m_ctrl}, wdata, be);
                    m_ctrl = t[2:0];
                end
                8'h08: m_count = bmerge(old_count, wdata, be);
                8'h0C: begin
                    t = bmerge({16'd0, m_pre}, wdata, be);
                    m_pre  = t[15:0];
                    m_pcnt = 0;
                end
                8'h10: m_cmp = bmerge(m_cmp, wdata, be);
                default: ;
            endcase
        end
        if (clr) m_match = 0;
        if (matched) m_match = 1;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00:   return m_led;
            8'h04:   return {29'd0, m_ctrl};
            8'h08:   return m_count;
            8'h0C:   return {16'd0, m_pre};
            8'h10:   return m_cmp;
            8'h14:   return {31'd0, m_match};
            default: return 0;
        endcase
    endfunction

    task automatic cycle();
        if (rst) model_step();
        else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; we = 1'b1; re = 1'b0;
        cycle();
        we = 1'b0; be = '0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; re = 1'b1;
        #1;
        check(name, rdata, exp);
        re = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        check({tag, ".led_out"}, 32'(LED_out), m_led);
        check({tag, ".irq"}, 32'(irq), 32'(m_match & m_ctrl[2]));
        for (int o = 0; o <= 8'h14; o += 4) begin
            rd_chk($sformatf("%s.rd%02h", tag, o), Base + 32'(o), model_read(8'(o)));
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{ALed,           32'hDEAD_BEEF, 4'b0011, ALed,           32'h0000_BEEF};
        tbl[1]  = '{32'h2000_0000,  32'hFFFF_FFFF, 4'b1111, ALed,           32'h0000_BEEF};
        tbl[2]  = '{ALed,           32'h00FF_0000, 4'b0100, ALed,           32'h0003_BEEF};
        tbl[3]  = '{ACnt,           32'hA5A5_5A5A, 4'b1111, ACnt,           32'hA5A5_5A5A};
        tbl[4]  = '{Base + 32'h0B,  32'h1122_3344, 4'b1000, ACnt,           32'h11A5_5A5A};
        tbl[5]  = '{APre,           32'hFFFF_1234, 4'b1111, APre,           32'h0000_1234};
        tbl[6]  = '{ACmp,           32'h0000_00AA, 4'b0001, ACmp,           32'hFFFF_FFAA};
        tbl[7]  = '{ACtrl,          32'hFFFF_FFFA, 4'b0001, ACtrl,          32'h0000_0002};
        tbl[8]  = '{Base + 32'h20,  32'hFFFF_FFFF, 4'b1111, Base + 32'h20,  32'h0000_0000};
        tbl[9]  = '{AStat,          32'h0000_0001, 4'b0001, AStat,          32'h0000_0000};
        tbl[10] = '{ACtrl,          32'h0000_0000, 4'b1111, ACtrl,          32'h0000_0000};
        tbl[11] = '{ALed,           32'h0000_0000, 4'b0000, ALed,           32'h0003_BEEF};

        // Reset
        model_reset();
        #25 rst = 1'b1;
        cycle();
        check("rst.led_out", 32'(LED_out), 32'd0);
        check("rst.irq", 32'(irq), 32'd0);
        rd_chk("rst.ctrl", ACtrl, 32'd0);
        rd_chk("rst.count", ACnt, 32'd0);
        rd_chk("rst.status", AStat, 32'd0);
        rd_chk("rst.compare", ACmp, 32'hFFFF_FFFF);

        // Register vector table
        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].a, tbl[i].d, tbl[i].b);
            rd_chk($sformatf("vec%0d", i), tbl[i].ra, tbl[i].exp);
            if (i == 0) check("vec0.led_out", 32'(LED_out), 32'h0000_BEEF);
        end
        addr = 32'h2000_0000; #1;
        check("hit.miss", 32'(hit), 32'd0);
        addr = Base + 32'hFC; #1;
        check("hit.top", 32'(hit), 32'd1);
        addr = ALed; re = 1'b0; #1;
        check("rd.no_re", rdata, 32'd0);
        chk_model("post_table");

        // Randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            logic [31:0] a, d;
            logic [7:0]  off;
            off = 8'($urandom_range(0, 7) * 4);
            a   = ($urandom_range(0, 9) == 0) ? (Base ^ 32'h0000_0100) | 32'(off)
                                               : Base | 32'(off) | 32'($urandom_range(0, 3));
            case (off)
                8'h08:   d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                                         : $urandom_range(0, 20);
                8'h0C:   d = $urandom_range(0, 3);
                8'h10:   d = $urandom_range(0, 20);
                default: d = $urandom;
            endcase
            addr = a; #1;
            check("rand.hit", 32'(hit), 32'(a[31:8] == Base[31:8]));
            if ($urandom_range(0, 5) == 0) begin
                wr(a, d, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111);
            end else begin
                cycle();
            end
            chk_model("rand");
        end

        // Auto-reload: PRESCALE=0, COMPARE=5
        wr(ACtrl, 0, 4'hF);
        wr(APre, 0, 4'hF);
        wr(ACmp, 5, 4'hF);
        wr(ACnt, 0, 4'hF);
        wr(AStat, 1, 4'hF);
        wr(ACtrl, 7, 4'hF);
        idle(5);
        rd_chk("ar.count5", ACnt, 32'd5);
        check("ar.irq_pre", 32'(irq), 32'd0);
        idle(1);
        check("ar.irq_match", 32'(irq), 32'd1);
        rd_chk("ar.reload", ACnt, 32'd0);
        rd_chk("ar.status", AStat, 32'd1);
        wr(AStat, 1, 4'h1);
        check("ar.w1c", 32'(irq), 32'd0);
        idle(4);
        check("ar.irq_gap", 32'(irq), 32'd0);
        idle(1);
        check("ar.irq_second", 32'(irq), 32'd1);
        rd_chk("ar.reload2", ACnt, 32'd0);

        // W1C on the same edge as a new match
        wr(AStat, 1, 4'h1);
        idle(4);
        rd_chk("race.count5", ACnt, 32'd5);
        wr(AStat, 1, 4'h1);
        check("race.irq", 32'(irq), 32'd1);
        rd_chk("race.status", AStat, 32'd1);
        wr(ACtrl, 0, 4'hF);
        wr(AStat, 32'hFFFF_FFFE, 4'hF);
        rd_chk("w1c.bit0_zero", AStat, 32'd1);
        wr(AStat, 1, 4'h1);
        rd_chk("w1c.status", AStat, 32'd0);
        check("w1c.irq", 32'(irq), 32'd0);

        // Prescale / one-shot: PRESCALE=3, COMPARE=2, EN|IRQ_EN
        wr(APre, 3, 4'hF);
        wr(ACmp, 2, 4'hF);
        wr(ACnt, 0, 4'hF);
        wr(ACtrl, 5, 4'hF);
        idle(3);
        rd_chk("ps.count_t3", ACnt, 32'd0);
        idle(1);
        rd_chk("ps.count_t4", ACnt, 32'd1);
        idle(7);
        rd_chk("ps.count_t11", ACnt, 32'd2);
        check("ps.irq_t11", 32'(irq), 32'd0);
        idle(1);
        check("ps.irq_t12", 32'(irq), 32'd1);
        rd_chk("ps.count_t12", ACnt, 32'd3);
        idle(4);
        rd_chk("ps.count_t16", ACnt, 32'd4);

        // Wrap and write priority: COMPARE=7
        wr(ACtrl, 0, 4'hF);
        wr(AStat, 1, 4'h1);
        wr(APre, 0, 4'hF);
        wr(ACmp, 7, 4'hF);
        wr(ACnt, 32'hFFFF_FFFF, 4'hF);
        wr(ACtrl, 5, 4'hF);
        idle(1);
        rd_chk("wrap.count", ACnt, 32'd0);
        rd_chk("wrap.status", AStat, 32'd0);
        wr(ACnt, 100, 4'hF);
        rd_chk("prio.count100", ACnt, 32'd100);
        wr(ACnt, 7, 4'hF);
        wr(ACnt, 50, 4'hF);
        rd_chk("prio.count50", ACnt, 32'd50);
        rd_chk("prio.no_match", AStat, 32'd0);
        idle(1);
        rd_chk("prio.count51", ACnt, 32'd51);
        chk_model("pre_reset");

        // Asynchronous reset mid-count
        wr(ALed, 32'h1234, 4'hF);
        #3 rst = 1'b0;
        #1;
        rd_chk("arst.count", ACnt, 32'd0);
        check("arst.led_out", 32'(LED_out), 32'd0);
        rd_chk("arst.compare", ACmp, 32'hFFFF_FFFF);
        model_reset();
        #20;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        chk_model("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_timer_led.md
# mmio_timer_led

Memory-mapped peripheral on the single-cycle CPU's data-memory port, directly downstream of the core's load/store path. Decodes one 256-byte window, holds the board LED register that drives `LED_out`, and provides a 32-bit prescaled timer with compare match, auto-reload and an interrupt line back to the core. Writes are registered; reads are combinational so a single-cycle load completes in its own cycle.

## Interface
- `BASE_ADDR`, default 32'h1000_0000, window base; only bits [31:8] are compared.
- `LED_W`, default 18, width of the LED register and `LED_out`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0); fixed polarity and synchronicity.
- `addr` in 32: byte address from the CPU ALU result.
- `wdata` in 32: store data.
- `be` in 4: byte enables for stores; `be[i]` gates `wdata[8i+7:8i]`.
- `we` in 1: store strobe, sampled at rising edge.
- `re` in 1: load strobe, combinational qualifier for `rdata`.
- `hit` out 1: `addr[31:8] == BASE_ADDR[31:8]`, combinational.
- `rdata` out 32: read data, combinational.
- `LED_out` out LED_W: LED register contents.
- `irq` out 1: timer interrupt request, level.

## Operation
- Register map (offset = `addr[7:0]`, `addr[1:0]` ignored): 0x00 LED (RW, low LED_W bits, upper bits read 0); 0x04 CTRL (RW, bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, others read 0); 0x08 COUNT (RW, 32 bit); 0x0C PRESCALE (RW, low 16 bits); 0x10 COMPARE (RW, 32 bit); 0x14 STATUS (bit0 MATCH, write-1-to-clear).
- Unmapped offsets: read 0, writes ignored. Access with `hit`=0: no state change, `rdata`=0.
- `rdata` = selected register when `re && hit`, else 0.
- Writes take effect on the rising edge where `we && hit`; only enabled bytes change.
- Prescaler: internal 16-bit `pre_cnt`. EN=0 holds `pre_cnt` at 0 and no ticks occur. EN=1: `tick` = (`pre_cnt == PRESCALE`); on tick `pre_cnt` <= 0, else `pre_cnt`+1. PRESCALE=0 gives a tick every cycle. Any write to PRESCALE clears `pre_cnt`.
- Counter on tick: if COUNT == COMPARE, set MATCH and COUNT <= AUTO_RELOAD ? 0 : COUNT+1; else COUNT <= COUNT+1. Increment wraps 32'hFFFF_FFFF -> 0 without flagging.
- `irq` = MATCH & IRQ_EN (combinational from registers, no extra flop).
- Simultaneous events: CPU write to COUNT beats tick increment (and suppresses that tick's match evaluation); match set beats STATUS W1C in the same cycle; STATUS write with bit0=0 has no effect.

## Timing
- Reset (`rst`=0, asynchronous): LED=0, CTRL=0, COUNT=0, PRESCALE=0, COMPARE=32'hFFFF_FFFF, MATCH=0, `pre_cnt`=0; hence `LED_out`=0, `irq`=0. Reset mid-count aborts immediately; release is seen on the next rising edge.
- Store latency: register visible on `rdata` / `LED_out` the cycle after the write edge.
- Load latency: 0 cycles (combinational, same cycle as `re`).
- Match period with AUTO_RELOAD: (COMPARE+1) × (PRESCALE+1) cycles.
- MATCH and `irq` rise on the edge that evaluates the matching tick.

## Test plan
- Reset: hold `rst`=0 20 ns, release -> `LED_out`=0, `irq`=0, reads of 0x04/0x08/0x14 = 0, 0x10 = 32'hFFFF_FFFF.
- LED byte-enable: store 32'hDEAD_BEEF to 0x1000_0000 with `be`=4'b0011 -> `LED_out`=18'h0BEEF next cycle, read returns 32'h0000_BEEF; address 0x2000_0000 -> `hit`=0, LED unchanged.
- Auto-reload: PRESCALE=0, COMPARE=5, CTRL=3'b111 -> COUNT 0..5, MATCH/`irq` rise after sixth tick, COUNT back to 0, next match 6 cycles later.
- Prescale/one-shot: PRESCALE=3, COMPARE=2, CTRL=3'b101 -> COUNT advances every 4 cycles, MATCH at 12 cycles after enable, COUNT continues to 3.
- W1C race: store 1 to 0x14 on the same edge a new match occurs -> MATCH stays 1; store 1 with no match -> MATCH=0, `irq`=0.
- Write priority and wrap: COUNT=32'hFFFF_FFFF, EN=1, COMPARE=7 -> COUNT wraps to 0 with no MATCH; store COUNT=100 on a tick edge -> COUNT reads 100, not 101.
